// File: rtl/adc_ctrl_pkg.sv
// Shared types for the ADC conversion arbiter.
//   state_t : arbiter FSM states (IDLE, CONV, GAP)
//   CH_W    : ADC channel-select width
package adc_ctrl_pkg;

   localparam int unsigned CH_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/adc_conv_arbiter_if.sv
// SAR ADC macro bus.
//   adc_soc    : start-of-conversion level (arbiter -> ADC)
//   adc_ch_sel : channel select             (arbiter -> ADC)
//   adc_eoc    : end-of-conversion level    (ADC -> arbiter)
//   adc_data   : conversion result, valid while adc_eoc high (ADC -> arbiter)
interface adc_conv_arbiter_if
   import adc_ctrl_pkg::*;
#(
   parameter int unsigned DW = 12
) ();

   logic            adc_soc;
   logic [CH_W-1:0] adc_ch_sel;
   logic            adc_eoc;
   logic [DW-1:0]   adc_data;

   modport master (
      output adc_soc,
      output adc_ch_sel,
      input  adc_eoc,
      input  adc_data
   );

   modport slave (
      input  adc_soc,
      input  adc_ch_sel,
      output adc_eoc,
      output adc_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
//   req       : request vector
//   ptr       : highest-priority index
//   win_oh_c  : one-hot winner
//   win_idx_c : winner index
//   win_vld_c : at least one request present
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] win_oh_c,
   output logic [PW-1:0]   win_idx_c,
   output logic            win_vld_c
);

   // Scan NREQ positions starting at ptr; the first hit wins.
   always_comb begin
      int unsigned idx;
      logic [PW-1:0] idx_p;
      win_oh_c  = '0;
      win_idx_c = '0;
      win_vld_c = 1'b0;
      idx       = 0;
      idx_p     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx   = (32'(ptr) + i) % NREQ;
         idx_p = PW'(idx);
         if (!win_vld_c && req[idx_p]) begin
            win_vld_c        = 1'b1;
            win_idx_c        = idx_p;
            win_oh_c[idx_p]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_conv_arbiter.sv
// Round-robin scheduler sharing one SAR ADC between NREQ requesters.
//   clk, rst_n  : clock, async active-low reset
//   en          : allow new grants (in-flight conversion always completes)
//   gap_cycles  : soc-low guard after eoc falls (gap_cycles+1 cycles)
//   timeout     : max CONV cycles waiting for eoc edge, 0 = no timeout
//   req, req_ch : per-requester request level and 3-bit channel
//   gnt/done/err: one-hot single-cycle pulses to the requester
//   result      : last captured conversion, held until next capture
//   busy        : high from grant until back in IDLE
//   adc         : ADC macro bus (master side)
module adc_conv_arbiter
   import adc_ctrl_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 12,
   parameter int unsigned TW   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [7:0]           gap_cycles,
   input  logic [TW-1:0]        timeout,
   input  logic [NREQ-1:0]      req,
   input  logic [CH_W*NREQ-1:0] req_ch,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      err,
   output logic [DW-1:0]        result,
   output logic                 busy,
   adc_conv_arbiter_if.master   adc
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [TW-1:0]   cnt;
   logic [7:0]      gap_cnt;
   logic            eoc_q;

   logic [NREQ-1:0] win_oh_c;
   logic [PW-1:0]   win_idx_c;
   logic            win_vld_c;
   logic [CH_W-1:0] win_ch_c;
   logic [NREQ-1:0] owner_oh_c;
   logic [TW-1:0]   cnt_inc_c;
   logic            eoc_rise_c;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .req       (req),
      .ptr       (ptr),
      .win_oh_c  (win_oh_c),
      .win_idx_c (win_idx_c),
      .win_vld_c (win_vld_c)
   );

   // Channel of the current winner.
   always_comb begin
      win_ch_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_idx_c == PW'(i)) begin
            win_ch_c = req_ch[i*CH_W +: CH_W];
         end
      end
   end

   assign owner_oh_c = NREQ'(1) << owner;
   assign cnt_inc_c  = cnt + TW'(1);
   // eoc already high when CONV is entered is stale and never forms an edge.
   assign eoc_rise_c = adc.adc_eoc & ~eoc_q;

   // Arbiter FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         ptr            <= '0;
         owner          <= '0;
         cnt            <= '0;
         gap_cnt        <= '0;
         eoc_q          <= 1'b0;
         gnt            <= '0;
         done           <= '0;
         err            <= '0;
         result         <= '0;
         busy           <= 1'b0;
         adc.adc_soc    <= 1'b0;
         adc.adc_ch_sel <= '0;
      end else begin
         gnt   <= '0;
         done  <= '0;
         err   <= '0;
         eoc_q <= adc.adc_eoc;
         case (state)
            IDLE: begin
               if (en && win_vld_c) begin
                  gnt            <= win_oh_c;
                  adc.adc_ch_sel <= win_ch_c;
                  adc.adc_soc    <= 1'b1;
                  owner          <= win_idx_c;
                  ptr            <= (win_idx_c == PW'(NREQ - 1)) ? '0 : win_idx_c + PW'(1);
                  cnt            <= '0;
                  busy           <= 1'b1;
                  state          <= CONV;
               end
            end
            CONV: begin
               cnt <= cnt_inc_c;
               if (eoc_rise_c) begin
                  result      <= adc.adc_data;
                  done        <= owner_oh_c;
                  adc.adc_soc <= 1'b0;
                  gap_cnt     <= '0;
                  state       <= GAP;
               end else if ((timeout != '0) && (cnt_inc_c == timeout)) begin
                  err         <= owner_oh_c;
                  adc.adc_soc <= 1'b0;
                  gap_cnt     <= '0;
                  state       <= GAP;
               end
            end
            GAP: begin
               // Guard count only runs while eoc is low; restarts if eoc reasserts.
               if (adc.adc_eoc) begin
                  gap_cnt <= '0;
               end else if (gap_cnt == gap_cycles) begin
                  gap_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 8'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
